alu_result_fifo: RTL
====================

// Module: alu_result_fifo
// PURPOSE
//   Downstream stage of the 4-bit ALU: captures each ALU result (ALU_Out, Error, Opcode)
//   into a small synchronous FIFO with valid/ready handshakes on both sides.
//   Decouples the ALU from the writeback/consumer and maintains a sticky overflow flag.
//   Sits between the ALU outputs and the register-file writeback port.
// PARAMETERS
//   DEPTH    4   number of entries; power of 2, >= 2
//   DATA_W   4   result width; must match ALU_Out
// PORTS
//   clk         in   1       single clock, all state updates on posedge
//   rst         in   1       asynchronous, active-high reset
//   In_Valid    in   1       ALU result present this cycle
//   In_Ready    out  1       FIFO can accept; = !full
//   ALU_Out     in   DATA_W  ALU result
//   Error       in   1       ALU overflow flag for this result
//   Opcode      in   2       op that produced the result (00 ADD, 01 SUB, 10 NAND, 11 XOR)
//   Out_Valid   out  1       head entry valid; = !empty
//   Out_Ready   in   1       consumer takes head this cycle
//   Out_Data    out  DATA_W  head result
//   Out_Error   out  1       head Error bit
//   Out_Opcode  out  2       head Opcode
//   Count       out  $clog2(DEPTH)+1  current occupancy
//   Sticky_Err  out  1       set when any entry with Error=1 is pushed
//   Clr_Err     in   1       synchronous clear of Sticky_Err (and Err_Count)
// BEHAVIOUR
//   - Reset: wr_ptr=rd_ptr=0, Count=0, In_Ready=1, Out_Valid=0, Sticky_Err=0; storage = 0,
//     so Out_Data/Out_Error/Out_Opcode = 0. Reset mid-operation discards all entries.
//   - push = In_Valid & In_Ready; pop = Out_Valid & Out_Ready; evaluated at posedge.
//   - Latency: entry pushed in cycle N is visible on Out_* (Out_Valid=1) in cycle N+1.
//   - Out_* driven combinationally from storage at rd_ptr; stable while Out_Valid & !Out_Ready.
//   - Occupancy states EMPTY (Count=0), PARTIAL, FULL (Count=DEPTH):
//     EMPTY: push only -> PARTIAL; pop impossible (Out_Valid=0).
//     PARTIAL: push&pop -> Count unchanged; push -> +1 (FULL at DEPTH); pop -> -1 (EMPTY at 0).
//     FULL: In_Ready=0, push ignored even if Out_Ready=1 same cycle (no bypass); pop -> PARTIAL.
//   - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
//   - Sticky_Err: next = (Sticky_Err & !Clr_Err) | (push & Error). Set wins over clear.
//   - In_Valid while In_Ready=0: no state change; upstream must hold data (ALU is combinational).
//   - Data stored unmodified; no arithmetic on results.
// CONFIGURATION
//   ALU_RESFIFO_ERRCNT_EN defined: adds output Err_Count [7:0]; increments on push&Error,
//     saturates at 8'hFF, Clr_Err zeroes it (increment wins over clear in the same cycle,
//     giving 1); reset to 0.
//   Not defined: Err_Count port and counter absent; all other behaviour identical.
// STRUCTURE
//   Shared package alu_pkg: localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_NAND=2'b10,
//     OP_XOR=2'b11, ALU_DATA_W=4; entry layout {Opcode, Error, Data} width constant.
//   One sub-module: alu_fifo_ctrl (pointers, Count, full/empty); storage and flags in top.
// TESTING
//   1 Reset, then push {ADD,5,Err0} (2+3) -> next cycle Out_Valid=1, Out_Data=4'h5,
//     Out_Error=0, Out_Opcode=00, Count=1, Sticky_Err=0.
//   2 Push 4 entries (5,A/E1,4,7/E1) with Out_Ready=0 -> Count=4, In_Ready=0; 5th push
//     ignored; pop all -> order 5,A,4,7 with Error 0,1,0,1; Sticky_Err=1.
//   3 FULL, In_Valid=1 and Out_Ready=1 same cycle -> Count 4->3, new entry not stored.
//   4 PARTIAL (Count=2), push and pop same cycle, 2*DEPTH times -> Count stays 2,
//     pointers wrap, output order preserved.
//   5 Push {SUB,7,Err1} with Clr_Err=1 same cycle -> Sticky_Err=1; next cycle Clr_Err=1,
//     no push -> Sticky_Err=0.
//   6 Assert rst asynchronously with Count=3 -> immediately Count=0, Out_Valid=0, In_Ready=1;
//     with ALU_RESFIFO_ERRCNT_EN, Err_Count=0 and 300 error pushes saturate at 8'hFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: opcodes, result width and
// stored entry layout, plus the occupancy state encoding used by the result FIFO.
package alu_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_XOR  = 2'b11;

    localparam int ALU_DATA_W  = 4;
    // Stored entry is {Opcode, Error, Data}
    localparam int ALU_ENTRY_W = 2 + 1 + ALU_DATA_W;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'b00,
        OCC_PARTIAL = 2'b01,
        OCC_FULL    = 2'b10
    } occ_state_t;

endpackage

// File: rtl/alu_fifo_ctrl.sv
// Result FIFO control: read/write pointers, occupancy count and the
// EMPTY/PARTIAL/FULL state, with push/pop qualified against full/empty.
module alu_fifo_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       out_ready,
    output logic                       push,
    output logic                       pop,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    occ_state_t          state_r;
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic                push_s;
    logic                pop_s;

    // No bypass: a full FIFO refuses the push even when the head is popped this cycle
    assign push_s = in_valid & (state_r != OCC_FULL);
    assign pop_s  = out_ready & (state_r != OCC_EMPTY);

    assign push   = push_s;
    assign pop    = pop_s;
    assign wr_ptr = wr_ptr_r;
    assign rd_ptr = rd_ptr_r;
    assign count  = count_r;
    assign full   = (state_r == OCC_FULL);
    assign empty  = (state_r == OCC_EMPTY);

    // Occupancy FSM with pointer and count bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= OCC_EMPTY;
            count_r  <= {CNT_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end

            case (state_r)
                OCC_EMPTY: begin
                    if (push_s) begin
                        count_r <= CNT_W'(1);
                        state_r <= OCC_PARTIAL;
                    end else begin
                        count_r <= count_r;
                        state_r <= OCC_EMPTY;
                    end
                end
                OCC_PARTIAL: begin
                    if (push_s && !pop_s) begin
                        count_r <= count_r + CNT_W'(1);
                        state_r <= (count_r == CNT_W'(DEPTH - 1)) ? OCC_FULL : OCC_PARTIAL;
                    end else if (pop_s && !push_s) begin
                        count_r <= count_r - CNT_W'(1);
                        state_r <= (count_r == CNT_W'(1)) ? OCC_EMPTY : OCC_PARTIAL;
                    end else begin
                        count_r <= count_r;
                        state_r <= OCC_PARTIAL;
                    end
                end
                OCC_FULL: begin
                    if (pop_s) begin
                        count_r <= count_r - CNT_W'(1);
                        state_r <= OCC_PARTIAL;
                    end else begin
                        count_r <= count_r;
                        state_r <= OCC_FULL;
                    end
                end
                default: begin
                    // Illegal encoding: fall back to a clean empty FIFO
                    state_r  <= OCC_EMPTY;
                    count_r  <= {CNT_W{1'b0}};
                    wr_ptr_r <= {PTR_W{1'b0}};
                    rd_ptr_r <= {PTR_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_result_fifo.sv
// ALU result FIFO: buffers {Opcode, Error, ALU_Out} with valid/ready on both sides
// and a sticky error flag. Define ALU_RESFIFO_ERRCNT_EN to add the saturating Err_Count output.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       In_Valid,
    output logic                       In_Ready,
    input  logic [DATA_W-1:0]          ALU_Out,
    input  logic                       Error,
    input  logic [1:0]                 Opcode,
    output logic                       Out_Valid,
    input  logic                       Out_Ready,
    output logic [DATA_W-1:0]          Out_Data,
    output logic                       Out_Error,
    output logic [1:0]                 Out_Opcode,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Sticky_Err,
    input  logic                       Clr_Err
`ifdef ALU_RESFIFO_ERRCNT_EN
    ,
    output logic [7:0]                 Err_Count
`endif
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = DATA_W + 3;

    logic                  push_s;
    logic                  pop_s;
    logic                  full_s;
    logic                  empty_s;
    logic [PTR_W-1:0]      wr_ptr_s;
    logic [PTR_W-1:0]      rd_ptr_s;
    logic [PTR_W:0]        count_s;
    logic [ENTRY_W-1:0]    mem_r [DEPTH];
    logic [ENTRY_W-1:0]    head_s;
    logic                  sticky_r;

    alu_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (In_Valid),
        .out_ready (Out_Ready),
        .push      (push_s),
        .pop       (pop_s),
        .wr_ptr    (wr_ptr_s),
        .rd_ptr    (rd_ptr_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Entry storage; cleared on reset so the head reads as zero when empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {ENTRY_W{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_s] <= {Opcode, Error, ALU_Out};
        end
    end

    // Set wins over clear so an error pushed during a clear is never lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_r <= 1'b0;
        end else begin
            sticky_r <= (sticky_r & ~Clr_Err) | (push_s & Error);
        end
    end

`ifdef ALU_RESFIFO_ERRCNT_EN
    logic [7:0] err_cnt_r;

    // Saturating error counter; an increment during a clear restarts it at one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_r <= 8'h00;
        end else if (push_s && Error && Clr_Err) begin
            err_cnt_r <= 8'h01;
        end else if (push_s && Error) begin
            err_cnt_r <= (err_cnt_r == 8'hFF) ? 8'hFF : err_cnt_r + 8'h01;
        end else if (Clr_Err) begin
            err_cnt_r <= 8'h00;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign Err_Count = err_cnt_r;
`endif

    assign head_s     = mem_r[rd_ptr_s];
    assign Out_Data   = head_s[DATA_W-1:0];
    assign Out_Error  = head_s[DATA_W];
    assign Out_Opcode = head_s[DATA_W+2:DATA_W+1];
    assign Out_Valid  = ~empty_s;
    assign In_Ready   = ~full_s;
    assign Count      = count_s;
    assign Sticky_Err = sticky_r;

endmodule
